serial_adder_ctrl: RTL and testbench

Bit-serial add/subtract controller that time-shares a single one-bit full-adder slice across a WIDTH-bit operation. It latches two operands on a start request and feeds the slice one bit pair per clock, LSB first. It holds the running carry in a register and assembles the result in a shift register. It presents the result with a one-cycle `done` pulse. It sits between the ALU sequencing logic and the shared full-adder datapath, replacing a WIDTH-bit ripple adder where area matters more than latency.

---
 rtl/serial_adder_ctrl_if.sv | 26 ++
 rtl/serial_adder_ctrl.sv | 95 +++++++++
 tb/tb_serial_adder_ctrl.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/serial_adder_ctrl_if.sv
// Operand/result bundle between the ALU sequencer (master) and the
// bit-serial add/subtract controller (slave).
interface serial_adder_ctrl_if #(
   parameter int WIDTH = 16
);
   logic             start;
   logic             op_sub;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             cin;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] sum;
   logic             cout;
   logic             overflow;

   modport master (
      output start, op_sub, a, b, cin,
      input  busy, done, sum, cout, overflow
   );

   modport slave (
      input  start, op_sub, a, b, cin,
      output busy, done, sum, cout, overflow
   );
endinterface

// File: rtl/serial_adder_ctrl.sv
// Bit-serial add/subtract controller: one full-adder slice reused for WIDTH
// cycles, LSB first, with the result published on a one-cycle done pulse.
module serial_adder_ctrl #(
   parameter int WIDTH = 16
) (
   input  logic                clk,
   input  logic                rst_n,
   serial_adder_ctrl_if.slave  bus
);
   localparam int CNT_W = $clog2(WIDTH) + 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           r_state;
   state_t           w_nextState;
   logic [WIDTH-1:0] r_a;
   logic [WIDTH-1:0] r_b;
   logic [WIDTH-1:0] r_res;
   logic             r_carry;
   logic [CNT_W-1:0] r_cnt;
   logic [WIDTH-1:0] r_sum;
   logic             r_cout;
   logic             r_overflow;

   logic             w_accept;
   logic             w_lastBit;
   logic             w_sumBit;
   logic             w_carryOut;
   logic [WIDTH-1:0] w_resNext;

   assign w_accept   = ((r_state == IDLE) || (r_state == DONE)) && bus.start;
   assign w_lastBit  = (r_cnt == CNT_W'(WIDTH - 1));
   assign w_sumBit   = r_a[0] ^ r_b[0] ^ r_carry;
   assign w_carryOut = (r_a[0] & r_b[0]) | (r_a[0] & r_carry) | (r_b[0] & r_carry);
   assign w_resNext  = {w_sumBit, r_res[WIDTH-1:1]};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_nextState;
      end
   end

   always_comb begin
      w_nextState = r_state;
      case (r_state)
         IDLE:    if (w_accept) w_nextState = RUN;
         RUN:     if (w_lastBit) w_nextState = DONE;
         DONE:    w_nextState = w_accept ? RUN : IDLE;
         default: w_nextState = IDLE;
      endcase
   end

   // Subtraction reuses the adder as a + ~b + 1, so B is inverted at load time.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_a        <= '0;
         r_b        <= '0;
         r_res      <= '0;
         r_carry    <= 1'b0;
         r_cnt      <= '0;
         r_sum      <= '0;
         r_cout     <= 1'b0;
         r_overflow <= 1'b0;
      end else if (w_accept) begin
         r_a     <= bus.a;
         r_b     <= bus.op_sub ? ~bus.b : bus.b;
         r_carry <= bus.op_sub ? 1'b1 : bus.cin;
         r_res   <= '0;
         r_cnt   <= '0;
      end else if (r_state == RUN) begin
         r_res   <= w_resNext;
         r_carry <= w_carryOut;
         r_a     <= r_a >> 1;
         r_b     <= r_b >> 1;
         r_cnt   <= r_cnt + 1'b1;
         if (w_lastBit) begin
            r_sum      <= w_resNext;
            r_cout     <= w_carryOut;
            r_overflow <= r_carry ^ w_carryOut;
         end
      end
   end

   assign bus.busy     = (r_state == RUN);
   assign bus.done     = (r_state == DONE);
   assign bus.sum      = r_sum;
   assign bus.cout     = r_cout;
   assign bus.overflow = r_overflow;
endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Directed bench for serial_adder_ctrl: expected results are queued at issue
// time and a monitor compares them whenever done pulses.
module tb_serial_adder_ctrl;
   localparam int W = 16;

   typedef struct packed {
      logic [W-1:0] sum;
      logic         cout;
      logic         ovf;
   } exp_t;

   logic clk;
   logic rst_n;
   int   checks;
   int   failures;
   exp_t sbQ[$];
   int   latency;

   serial_adder_ctrl_if #(.WIDTH(W)) bus ();

   serial_adder_ctrl #(.WIDTH(W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s actual=0x%0h expected=0x%0h at %0t", name, actual, expected, $time);
      end
   endtask

   // Called at a falling edge; the following rising edge accepts the operation.
   task automatic applyStimulus(input logic opSub, input logic [W-1:0] aIn, input logic [W-1:0] bIn,
                                input logic cinIn, input logic [W-1:0] eSum, input logic eCout, input logic eOvf);
      exp_t e;
      bus.start  = 1'b1;
      bus.op_sub = opSub;
      bus.a      = aIn;
      bus.b      = bIn;
      bus.cin    = cinIn;
      e.sum  = eSum;
      e.cout = eCout;
      e.ovf  = eOvf;
      sbQ.push_back(e);
      @(negedge clk);
      bus.start  = 1'b0;
      bus.op_sub = 1'($urandom);
      bus.a      = W'($urandom);
      bus.b      = W'($urandom);
      bus.cin    = 1'($urandom);
   endtask

   // Counts falling edges until done, checking busy and result stability on the way.
   task automatic waitDone(input string name, input int expLat, output int lat);
      logic [W-1:0] heldSum;
      logic         busyOk;
      logic         stableOk;
      heldSum  = bus.sum;
      busyOk   = 1'b1;
      stableOk = 1'b1;
      lat      = 0;
      while (!bus.done && lat < 40) begin
         if (!bus.busy) busyOk = 1'b0;
         if (bus.sum !== heldSum) stableOk = 1'b0;
         @(negedge clk);
         lat++;
      end
      checkOutput({name, "_latency"}, 32'(lat), 32'(expLat));
      checkOutput({name, "_busyDuringRun"}, {31'd0, busyOk}, 32'd1);
      checkOutput({name, "_sumHeldDuringRun"}, {31'd0, stableOk}, 32'd1);
   endtask

   // Scoreboard monitor, sampling just after each rising edge.
   always @(posedge clk) begin
      #2;
      if (bus.done === 1'b1) begin
         checkOutput("busyWithDone", {31'd0, bus.busy}, 32'd0);
         if (sbQ.size() == 0) begin
            checkOutput("unexpectedDone", 32'd1, 32'd0);
         end else begin
            exp_t e;
            e = sbQ.pop_front();
            checkOutput("sum", {16'd0, bus.sum}, {16'd0, e.sum});
            checkOutput("cout", {31'd0, bus.cout}, {31'd0, e.cout});
            checkOutput("overflow", {31'd0, bus.overflow}, {31'd0, e.ovf});
         end
      end
   end

   initial begin
      #300000;
      $display("[TB] FAIL watchdog expired actual=running required=finished");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      checks     = 0;
      failures   = 0;
      rst_n      = 1'b0;
      bus.start  = 1'b0;
      bus.op_sub = 1'b0;
      bus.a      = '0;
      bus.b      = '0;
      bus.cin    = 1'b0;
      repeat (2) @(negedge clk);
      checkOutput("rst_sum", {16'd0, bus.sum}, 32'd0);
      checkOutput("rst_cout", {31'd0, bus.cout}, 32'd0);
      checkOutput("rst_overflow", {31'd0, bus.overflow}, 32'd0);
      checkOutput("rst_busy", {31'd0, bus.busy}, 32'd0);
      checkOutput("rst_done", {31'd0, bus.done}, 32'd0);
      rst_n = 1'b1;
      @(negedge clk);

      applyStimulus(1'b0, 16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0);
      waitDone("add5555", 16, latency);
      @(negedge clk);
      checkOutput("donePulseWidth", {31'd0, bus.done}, 32'd0);

      applyStimulus(1'b0, 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
      waitDone("addWrap", 16, latency);
      applyStimulus(1'b0, 16'h7FFF, 16'h0000, 1'b1, 16'h8000, 1'b0, 1'b1);
      waitDone("addOvf", 16, latency);
      applyStimulus(1'b1, 16'h0005, 16'h0007, 1'b1, 16'hFFFE, 1'b0, 1'b0);
      waitDone("subBorrow", 16, latency);
      applyStimulus(1'b1, 16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b1, 1'b1);
      waitDone("subOvf", 16, latency);
      @(negedge clk);

      // Start pulsed at bit 5 of a run must be dropped.
      applyStimulus(1'b0, 16'h1111, 16'h2222, 1'b0, 16'h3333, 1'b0, 1'b0);
      repeat (5) @(negedge clk);
      bus.start = 1'b1;
      bus.a     = 16'hAAAA;
      bus.b     = 16'h1111;
      @(negedge clk);
      bus.start = 1'b0;
      checkOutput("sumHeldAfterIgnoredStart", {16'd0, bus.sum}, 32'h7FFF);
      waitDone("ignoredStart", 10, latency);
      repeat (3) @(negedge clk);
      checkOutput("noQueuedOpBusy", {31'd0, bus.busy}, 32'd0);
      checkOutput("noQueuedOpDone", {31'd0, bus.done}, 32'd0);

      // Back-to-back: second start presented during the DONE cycle.
      applyStimulus(1'b0, 16'h0100, 16'h0200, 1'b0, 16'h0300, 1'b0, 1'b0);
      waitDone("b2bFirst", 16, latency);
      applyStimulus(1'b0, 16'h0001, 16'h0001, 1'b0, 16'h0002, 1'b0, 1'b0);
      checkOutput("b2bNoIdleGap", {31'd0, bus.busy}, 32'd1);
      waitDone("b2bSecond", 16, latency);
      checkOutput("b2bDoneSpacing", 32'(latency + 1), 32'd17);
      @(negedge clk);

      // Reset mid-run discards the pending operation.
      applyStimulus(1'b0, 16'hAAAA, 16'h5555, 1'b0, 16'hFFFF, 1'b0, 1'b0);
      repeat (8) @(negedge clk);
      rst_n = 1'b0;
      void'(sbQ.pop_back());
      #1;
      checkOutput("midRst_sum", {16'd0, bus.sum}, 32'd0);
      checkOutput("midRst_cout", {31'd0, bus.cout}, 32'd0);
      checkOutput("midRst_overflow", {31'd0, bus.overflow}, 32'd0);
      checkOutput("midRst_busy", {31'd0, bus.busy}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      checkOutput("postRst_idleBusy", {31'd0, bus.busy}, 32'd0);
      checkOutput("postRst_idleDone", {31'd0, bus.done}, 32'd0);
      applyStimulus(1'b0, 16'h00FF, 16'h0F01, 1'b1, 16'h1001, 1'b0, 1'b0);
      waitDone("postRstAdd", 16, latency);
      @(negedge clk);

      checkOutput("scoreboardDrained", 32'(sbQ.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
